// File: rtl/adder_sched_pkg.sv
// ---------------------------------------------------------------------------
// adder_sched_pkg
// Shared types and helpers for the round-robin adder scheduler.
//
// Contents:
//   slot_state_e : state of the one-entry output slot (EMPTY / FULL)
//   rr_pick_t    : result of a round-robin search (found flag + index)
//   next_rr()    : round-robin search over a request vector. Sized for the
//                  largest supported requester count (16); callers pass the
//                  real count so the search wraps at the right place.
// ---------------------------------------------------------------------------
package adder_sched_pkg;

  localparam int MAX_REQ = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Scan the request vector starting at ptr and wrapping modulo nreq.
  // The first set bit wins. Positions at or above nreq are never examined,
  // so the unused upper part of the vector may hold anything.
  function automatic rr_pick_t next_rr(input logic [MAX_IDW-1:0] ptr,
                                       input logic [MAX_REQ-1:0] valid,
                                       input int unsigned        nreq);
    rr_pick_t    pick;
    int unsigned pos;
    pick = '0;
    pos  = 0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      pos = ({28'd0, ptr} + k) % nreq;
      if ((k < nreq) && !pick.found && valid[MAX_IDW'(pos)]) begin
        pick.found = 1'b1;
        pick.idx   = MAX_IDW'(pos);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/n_adder.sv
// ---------------------------------------------------------------------------
// n_adder
// Plain N-bit ripple/inferred adder with carry-in and carry-out.
// {co, s} is the (N+1)-bit unsigned sum a + b + ci.
//
// Ports:
//   a, b : N-bit operands
//   ci   : carry-in
//   s    : N-bit sum
//   co   : carry-out
// ---------------------------------------------------------------------------
module n_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  // Zero-extend everything to N+1 bits so the top bit is the carry-out.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: combinational one-hot grant plus a registered
// priority pointer. The pointer moves to one past the winner only when a
// grant is actually issued, so a requester that is skipped keeps its place.
//
// Ports:
//   clk         : clock, rising edge
//   rstn        : synchronous active-low reset (pointer returns to 0)
//   en          : arbitration allowed this cycle (downstream can take a result)
//   valid       : per-requester request
//   grant       : one-hot grant, all-zero when disabled or nothing requested
//   grant_idx   : index of the granted requester (meaningful with grant_found)
//   grant_found : a grant is issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_found
);

  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  // Widen the request vector to the package's fixed search width and run
  // the round-robin search from the current pointer.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    pick                  = next_rr(MAX_IDW'(ptr_q), valid_ext, NREQ);
  end

  assign grant_found = en & pick.found;
  assign grant_idx   = IDW'(pick.idx);

  // Decode the winning index into the one-hot grant vector.
  always_comb begin
    grant = '0;
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer advances past the winner, wrapping at NREQ (which need not be a
  // power of two, hence the explicit compare instead of relying on overflow).
  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      if (grant_idx == IDW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// ---------------------------------------------------------------------------
// adder_rr_sched
// Shares one n_adder between NREQ requesters. A round-robin arbiter picks at
// most one requester per cycle whenever the one-entry output slot can take a
// result (slot empty, or full and being drained this cycle). The granted
// operands go through the shared adder and the sum is registered into the
// slot together with the requester index, one cycle after the accept.
//
// Optional build macro:
//   ADDER_OVF_DETECT_EN : adds rsp_ovf, the registered signed-overflow flag.
//
// Ports:
//   clk        : clock, rising edge
//   rstn       : synchronous active-low reset
//   req_valid  : per-requester operation valid
//   req_ready  : per-requester accept, one-hot or zero (combinational)
//   req_a      : per-requester operand A
//   req_b      : per-requester operand B
//   req_ci     : per-requester carry-in
//   rsp_valid  : slot holds a result
//   rsp_ready  : consumer takes the result
//   rsp_id     : index of the requester that issued the result
//   rsp_s      : sum
//   rsp_co     : carry-out
//   rsp_ovf    : signed overflow (only with ADDER_OVF_DETECT_EN)
// ---------------------------------------------------------------------------
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0][N-1:0]  req_a,
  input  logic [NREQ-1:0][N-1:0]  req_b,
  input  logic [NREQ-1:0]         req_ci,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [N-1:0]            rsp_s,
  output logic                    rsp_co
`ifdef ADDER_OVF_DETECT_EN
  ,
  output logic                    rsp_ovf
`endif
);

  slot_state_e    slot_q;
  slot_state_e    slot_d;

  logic [IDW-1:0] rsp_id_q;
  logic [IDW-1:0] rsp_id_d;
  logic [N-1:0]   rsp_s_q;
  logic [N-1:0]   rsp_s_d;
  logic           rsp_co_q;
  logic           rsp_co_d;

  logic           slot_free;
  logic           arb_en;
  logic           accept;
  logic [IDW-1:0] grant_idx;

  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_ci;
  logic [N-1:0]   add_s;
  logic           add_co;

  // The slot can take a new result when it is empty or its current result
  // leaves this very cycle; that second case is what gives back-to-back
  // throughput without a bubble. Gating with rstn keeps req_ready at zero
  // while reset is asserted, before the reset edge has been seen.
  assign slot_free = (slot_q == EMPTY) || rsp_ready;
  assign arb_en    = rstn & slot_free;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .en          (arb_en),
    .valid       (req_valid),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_found (accept)
  );

  // The grant always lands on a valid requester, so grant_found is exactly
  // the req_valid & req_ready transfer condition.
  assign add_a  = req_a[grant_idx];
  assign add_b  = req_b[grant_idx];
  assign add_ci = req_ci[grant_idx];

  n_adder #(
    .N (N)
  ) u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

`ifdef ADDER_OVF_DETECT_EN
  logic rsp_ovf_q;
  logic rsp_ovf_d;
  logic add_ovf;

  // Same-signed operands producing a differently signed sum; the carry-in is
  // already folded into add_s.
  assign add_ovf = (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);
`endif

  // Slot next-state and data capture. Data registers only change on accept,
  // so a plain drain leaves the last result visible on rsp_s/rsp_id/rsp_co.
  always_comb begin
    slot_d   = slot_q;
    rsp_id_d = rsp_id_q;
    rsp_s_d  = rsp_s_q;
    rsp_co_d = rsp_co_q;
`ifdef ADDER_OVF_DETECT_EN
    rsp_ovf_d = rsp_ovf_q;
`endif
    case (slot_q)
      EMPTY: begin
        if (accept) begin
          slot_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          slot_d = FULL;
        end else if (rsp_ready) begin
          slot_d = EMPTY;
        end
      end
      default: begin
        slot_d = EMPTY;
      end
    endcase
    if (accept) begin
      rsp_id_d = grant_idx;
      rsp_s_d  = add_s;
      rsp_co_d = add_co;
`ifdef ADDER_OVF_DETECT_EN
      rsp_ovf_d = add_ovf;
`endif
    end
  end

  // Slot registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_q   <= EMPTY;
      rsp_id_q <= '0;
      rsp_s_q  <= '0;
      rsp_co_q <= 1'b0;
`ifdef ADDER_OVF_DETECT_EN
      rsp_ovf_q <= 1'b0;
`endif
    end else begin
      slot_q   <= slot_d;
      rsp_id_q <= rsp_id_d;
      rsp_s_q  <= rsp_s_d;
      rsp_co_q <= rsp_co_d;
`ifdef ADDER_OVF_DETECT_EN
      rsp_ovf_q <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = (slot_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_co    = rsp_co_q;
`ifdef ADDER_OVF_DETECT_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_sched
// Bench for adder_rr_sched (N=8, NREQ=4). A reference model predicts the
// grant each cycle from the round-robin rule and pushes the expected result
// into a queue; an independent monitor compares whatever the DUT presents
// against the head of that queue. Directed phases cover reset, carry and
// overflow, fairness and backpressure; a random phase follows.
// Define ADDER_OVF_DETECT_EN to also check rsp_ovf.
// ---------------------------------------------------------------------------
module tb_adder_rr_sched;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic [NREQ-1:0]        req_ci;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [N-1:0]           rsp_s;
  logic                   rsp_co;
`ifdef ADDER_OVF_DETECT_EN
  logic                   rsp_ovf;
`endif

  typedef struct {
    int id;
    int sum;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   seen_ids[$];
  bit   record = 1'b0;

  int   checks = 0;
  int   errors = 0;

  // Reference-model state, meaning "as it will be after the next edge".
  bit   m_full = 1'b0;
  int   m_ptr  = 0;
  int   wait_cnt[NREQ];
  bit   acc_now = 1'b0;
  int   acc_idx = 0;

  int              g;
  bit              found;
  bit              free_slot;
  logic [NREQ-1:0] exp_ready;
  int              us;
  int              ss;

  logic [N-1:0]    cap_s;
  logic [IDW-1:0]  cap_id;
  logic            cap_co;

  always #5 clk = ~clk;

  adder_rr_sched #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_co    (rsp_co)
`ifdef ADDER_OVF_DETECT_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: predict the grant from the round-robin rule, check the
  // handshake, and queue the expected result of every accepted operation.
  always @(negedge clk) begin
    if (!rstn) begin
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      exp_q.delete();
      m_full  = 1'b0;
      m_ptr   = 0;
      acc_now = 1'b0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      free_slot = !m_full || rsp_ready;
      found     = 1'b0;
      g         = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[(m_ptr + k) % NREQ]) begin
          found = 1'b1;
          g     = (m_ptr + k) % NREQ;
        end
      end
      exp_ready = '0;
      if (free_slot && found) exp_ready[g] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_full));
      acc_now = free_slot && found;
      acc_idx = g;
      if (acc_now) begin
        us = int'(req_a[g]) + int'(req_b[g]) + int'(req_ci[g]);
        ss = int'($signed(req_a[g])) + int'($signed(req_b[g])) + int'(req_ci[g]);
        exp_q.push_back('{id: g, sum: us % 512, ovf: int'(ss > 127 || ss < -128)});
        checkOutput("wait_bound", 32'(wait_cnt[g] < NREQ), 32'd1);
        m_ptr = (g + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || (acc_now && i == g)) wait_cnt[i] = 0;
        else if (acc_now) wait_cnt[i]++;
      end
      m_full = acc_now || (m_full && !rsp_ready);
    end
  end

  // Monitor: whatever the slot presents must match the oldest expected result.
  always @(negedge clk) begin
    if (rstn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        checkOutput("rsp_sum", 32'({rsp_co, rsp_s}), 32'(exp_q[0].sum));
`ifdef ADDER_OVF_DETECT_EN
        checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(exp_q[0].ovf));
`endif
        if (rsp_ready) begin
          if (record) seen_ids.push_back(int'(rsp_id));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    rstn      = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_ci    = '0;
    rsp_ready = 1'b1;

    // Reset held with every requester asking.
    applyStimulus(3);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_s", 32'(rsp_s), 32'd0);
    checkOutput("rst_rsp_co", 32'(rsp_co), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);

    // Single request from requester 0.
    rstn      = 1'b1;
    req_valid = 4'b0001;
    req_a[0]  = 8'd5;
    req_b[0]  = 8'd10;
    req_ci[0] = 1'b0;
    applyStimulus(1);
    checkOutput("t2_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t2_id", 32'(rsp_id), 32'd0);
    checkOutput("t2_sum", 32'({rsp_co, rsp_s}), 32'd15);

    // Signed overflow without carry, then carry without overflow.
    req_a[0]  = 8'd127;
    req_b[0]  = 8'd1;
    req_ci[0] = 1'b0;
    applyStimulus(1);
    checkOutput("t3a_sum", 32'({rsp_co, rsp_s}), 32'h080);
`ifdef ADDER_OVF_DETECT_EN
    checkOutput("t3a_ovf", 32'(rsp_ovf), 32'd1);
`endif
    req_a[0]  = 8'd30;
    req_b[0]  = 8'hF6;
    req_ci[0] = 1'b1;
    applyStimulus(1);
    checkOutput("t3b_sum", 32'({rsp_co, rsp_s}), 32'h115);
`ifdef ADDER_OVF_DETECT_EN
    checkOutput("t3b_ovf", 32'(rsp_ovf), 32'd0);
`endif
    req_valid = '0;
    applyStimulus(1);

    // Reset pulse mid-run returns the pointer to 0 for the fairness phase.
    rstn = 1'b0;
    applyStimulus(1);
    rstn = 1'b1;
    checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);

    // Fairness: all requesters valid, consumer always ready.
    for (int i = 0; i < NREQ; i++) begin
      req_a[i]  = N'($urandom);
      req_b[i]  = N'($urandom);
      req_ci[i] = 1'($urandom_range(0, 1));
    end
    req_valid = '1;
    seen_ids.delete();
    record = 1'b1;
    applyStimulus(7);
    record = 1'b0;
    checkOutput("fair_count", 32'(seen_ids.size()), 32'd6);
    for (int k = 0; k < 6 && k < seen_ids.size(); k++) begin
      checkOutput("fair_id", 32'(seen_ids[k]), 32'(k % NREQ));
    end

    // Backpressure: slot full, consumer stalls for 5 cycles.
    cap_s     = rsp_s;
    cap_id    = rsp_id;
    cap_co    = rsp_co;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_s", 32'(rsp_s), 32'(cap_s));
      checkOutput("stall_id", 32'(rsp_id), 32'(cap_id));
      checkOutput("stall_co", 32'(rsp_co), 32'(cap_co));
    end
    // Grants so far were 0,1,2,3,0,1,2: the release cycle must serve 3.
    rsp_ready = 1'b1;
    applyStimulus(1);
    checkOutput("release_id", 32'(rsp_id), 32'd3);
    checkOutput("release_valid", 32'(rsp_valid), 32'd1);

    // Random traffic; a requester keeps its operands until it is accepted,
    // but may withdraw its request at any time.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      rstn = (cyc != 500);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !(acc_now && acc_idx == i)) begin
          req_valid[i] = ($urandom_range(0, 15) != 0);
        end else begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i]     = N'($urandom);
          req_b[i]     = N'($urandom);
          req_ci[i]    = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(1);
    end

    // Drain everything still pending.
    rstn      = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    applyStimulus(3);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_valid", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
